// File: rtl/lsu.sv
// lsu: load/store unit behind the ALU.
//
// Takes the ALU result and performs at most one byte/half/word/double memory
// access. The access goes over a valid/ready request channel and comes back on
// a valid-only response channel. The result is sign- or zero-extended and
// handed to the WBU. Non-memory ops pass the ALU result through with one cycle
// of latency. Only one op is in flight at a time.
//
// Handshake rule used on every valid/ready pair below: a transfer happens on a
// rising clk edge where valid and ready are both 1. A producer holding valid
// keeps its payload stable until that edge. The response channel has no ready
// and is consumed only in WAIT.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When it is defined, an access
// whose offset is not a multiple of its size skips memory. Such an access
// completes with data 0 and lsu_wbu_misalign=1.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exu_lsu_valid/ready      upstream op handshake
//   lsu_addr                 effective address or pass-through value
//   lsu_wdata                store data (low bytes used)
//   lsu_load/store           op kind (both set -> load)
//   lsu_size                 0=B 1=H 2=W 3=D
//   lsu_unsigned             zero-extend loads
//   lsu_rd                   destination register index
//   mem_req_*                aligned doubleword request with byte strobes
//   mem_rsp_valid/rdata      response for loads and stores
//   lsu_wbu_valid/ready      result handshake to WBU
//   lsu_wbu_data/rd          result payload
//   lsu_wbu_misalign         misaligned-access flag
//   lsu_dbg_state            FSM state (0=IDLE 1=REQ 2=WAIT 3=DONE)
// All outputs read 0 while rst is high.
module lsu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_lsu_valid,
  output logic              exu_lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic              lsu_load,
  input  logic              lsu_store,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_unsigned,
  input  logic [4:0]        lsu_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              lsu_wbu_valid,
  input  logic              lsu_wbu_ready,
  output logic [DATA_W-1:0] lsu_wbu_data,
  output logic [4:0]        lsu_wbu_rd,
  output logic              lsu_wbu_misalign,
  output logic [1:0]        lsu_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [4:0]        rd_q, rd_d;
  logic              misalign_q, misalign_d;

  // Lane steering from the latched offset.
  logic [2:0]        off;
  logic [5:0]        lane_shift;
  logic [7:0]        size_mask;
  logic [7:0]        lane_mask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] rsp_shifted;
  logic [DATA_W-1:0] load_ext;

  assign off        = addr_q[2:0];
  assign lane_shift = {off, 3'b000};
  // Shifts drop store bytes past lane 7 and zero-fill load bytes past lane 7.
  assign lane_mask   = size_mask << off;
  assign lane_wdata  = wdata_q << lane_shift;
  assign rsp_shifted = mem_rsp_rdata >> lane_shift;

  always_comb begin
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, rsp_shifted[7:0]}
                             : {{56{rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, rsp_shifted[15:0]}
                             : {{48{rsp_shifted[15]}}, rsp_shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, rsp_shifted[31:0]}
                             : {{32{rsp_shifted[31]}}, rsp_shifted[31:0]};
      default: load_ext = rsp_shifted;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] o);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return o[0];
      2'd2:    return |o[1:0];
      default: return |o;
    endcase
  endfunction
`endif

  // Next state, register updates and outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    load_d     = load_q;
    store_d    = store_q;
    uns_d      = uns_q;
    size_d     = size_q;
    rd_d       = rd_q;
    misalign_d = misalign_q;

    exu_lsu_ready    = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wen      = 1'b0;
    mem_req_wdata    = '0;
    mem_req_wmask    = '0;
    lsu_wbu_valid    = 1'b0;
    lsu_wbu_data     = '0;
    lsu_wbu_rd       = '0;
    lsu_wbu_misalign = 1'b0;
    lsu_dbg_state    = state_q;

    case (state_q)
      IDLE: begin
        exu_lsu_ready = 1'b1;
        if (exu_lsu_valid) begin
          addr_d     = lsu_addr;
          wdata_d    = lsu_wdata;
          load_d     = lsu_load;
          // A load/store collision is resolved in favour of the load.
          store_d    = lsu_store & ~lsu_load;
          uns_d      = lsu_unsigned;
          size_d     = lsu_size;
          rd_d       = lsu_rd;
          misalign_d = 1'b0;
          result_d   = '0;
          if (lsu_load || lsu_store) begin
            state_d = REQ;
`ifdef LSU_MISALIGN_CHECK_EN
            if (is_misaligned(lsu_size, lsu_addr[2:0])) begin
              misalign_d = 1'b1;
              state_d    = DONE;
            end
`endif
          end else begin
            result_d = lsu_addr;
            state_d  = DONE;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        mem_req_wen   = store_q;
        mem_req_wdata = store_q ? lane_wdata : '0;
        mem_req_wmask = store_q ? lane_mask : 8'h00;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          result_d = load_q ? load_ext : '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        lsu_wbu_valid    = 1'b1;
        lsu_wbu_data     = result_q;
        lsu_wbu_rd       = rd_q;
        lsu_wbu_misalign = misalign_q;
        if (lsu_wbu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet during reset, even mid-operation.
    if (rst) begin
      exu_lsu_ready    = 1'b0;
      mem_req_valid    = 1'b0;
      mem_req_addr     = '0;
      mem_req_wen      = 1'b0;
      mem_req_wdata    = '0;
      mem_req_wmask    = '0;
      lsu_wbu_valid    = 1'b0;
      lsu_wbu_data     = '0;
      lsu_wbu_rd       = '0;
      lsu_wbu_misalign = 1'b0;
      lsu_dbg_state    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      rd_q       <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      load_q     <= load_d;
      store_q    <= store_d;
      uns_q      <= uns_d;
      size_q     <= size_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
module tb_lsu;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        exu_lsu_valid = 1'b0;
  logic        exu_lsu_ready;
  logic [63:0] lsu_addr = '0;
  logic [63:0] lsu_wdata = '0;
  logic        lsu_load = 1'b0;
  logic        lsu_store = 1'b0;
  logic [1:0]  lsu_size = '0;
  logic        lsu_unsigned = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic        lsu_wbu_valid;
  logic        lsu_wbu_ready = 1'b0;
  logic [63:0] lsu_wbu_data;
  logic [4:0]  lsu_wbu_rd;
  logic        lsu_wbu_misalign;
  logic [1:0]  lsu_dbg_state;

  lsu dut (
    .clk(clk), .rst(rst),
    .exu_lsu_valid(exu_lsu_valid), .exu_lsu_ready(exu_lsu_ready),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_rd(lsu_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .lsu_wbu_valid(lsu_wbu_valid), .lsu_wbu_ready(lsu_wbu_ready),
    .lsu_wbu_data(lsu_wbu_data), .lsu_wbu_rd(lsu_wbu_rd),
    .lsu_wbu_misalign(lsu_wbu_misalign), .lsu_dbg_state(lsu_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-by-byte view of the access: the op covers bytes off..off+nbytes-1 of
  // the aligned doubleword, and any byte that lands past lane 7 does not exist.
  function automatic logic [63:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [63:0] addr, input logic [63:0] rdata);
    int          off = int'(addr[2:0]);
    int          nb  = 1 << size;
    logic [63:0] v   = '0;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input logic [1:0] size, input logic [63:0] addr);
    int         off = int'(addr[2:0]);
    logic [7:0] m   = '0;
    for (int i = 0; i < (1 << size); i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [63:0] wdata);
    int          off = int'(addr[2:0]);
    logic [63:0] v   = '0;
    for (int b = 0; b < 8; b++)
      if (b >= off) v[8*b +: 8] = wdata[8*(b-off) +: 8];
    return v;
  endfunction

  function automatic logic model_mis(input logic ld, input logic st, input logic [1:0] size,
                                     input logic [63:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    return (ld | st) && ((int'(addr[2:0]) % (1 << size)) != 0);
`else
    return 1'b0 & ld & st & size[0] & addr[0];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    exu_lsu_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; lsu_wbu_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst.exu_ready", exu_lsu_ready, 0);
    check("rst.wbu_valid", lsu_wbu_valid, 0);
    check("rst.req_valid", mem_req_valid, 0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", exu_lsu_ready, 1);
  endtask

  // Runs one op through the whole handshake sequence and checks every cycle.
  task automatic run_op(input string tag, input logic ld, input logic st,
                        input logic [1:0] size, input logic uns, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                        input int req_d, input int rsp_d, input int wbu_d,
                        input logic [63:0] exp_data, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic exp_mis);
    int          waited = 0;
    logic        goes_mem = (ld | st) & ~exp_mis;
    logic        exp_wen = st & ~ld;
    logic [63:0] exp;
    while (!exu_lsu_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, ".idle_ready"}, exu_lsu_ready, 1);
    if (!exu_lsu_ready) apply_reset();
    exu_lsu_valid = 1'b1; lsu_load = ld; lsu_store = st; lsu_size = size;
    lsu_unsigned = uns; lsu_addr = addr; lsu_wdata = wdata; lsu_rd = rd;
    exp_q.push_back(exp_data);
    @(posedge clk); #1;
    exu_lsu_valid = 1'b0;
    lsu_addr = {$urandom, $urandom}; lsu_wdata = {$urandom, $urandom};
    lsu_load = 1'($urandom); lsu_store = 1'($urandom); lsu_rd = 5'($urandom);
    if (goes_mem) begin
      for (int c = 0; c <= req_d; c++) begin
        check({tag, ".req_valid"}, mem_req_valid, 1);
        check({tag, ".req_addr"}, mem_req_addr, {addr[63:3], 3'b000});
        check({tag, ".req_wen"}, mem_req_wen, exp_wen);
        check({tag, ".req_wmask"}, mem_req_wmask, exp_mask);
        if (exp_wen) check({tag, ".req_wdata"}, mem_req_wdata, exp_wdata);
        check({tag, ".req_exu_ready"}, exu_lsu_ready, 0);
        mem_req_ready = (c == req_d);
        mem_rsp_valid = 1'($urandom);          // must be ignored in REQ
        mem_rsp_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      for (int c = 0; c <= rsp_d; c++) begin
        check({tag, ".wait_req_valid"}, mem_req_valid, 0);
        check({tag, ".wait_wbu_valid"}, lsu_wbu_valid, 0);
        if (c == rsp_d) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
        end
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
    end
    exp = exp_q.pop_front();
    for (int c = 0; c <= wbu_d; c++) begin
      check({tag, ".wbu_valid"}, lsu_wbu_valid, 1);
      check({tag, ".wbu_data"}, lsu_wbu_data, exp);
      check({tag, ".wbu_rd"}, lsu_wbu_rd, rd);
      check({tag, ".wbu_misalign"}, lsu_wbu_misalign, exp_mis);
      check({tag, ".done_req_valid"}, mem_req_valid, 0);
      check({tag, ".done_exu_ready"}, exu_lsu_ready, 0);
      lsu_wbu_ready = (c == wbu_d);
      mem_rsp_valid = 1'($urandom);            // must be ignored in DONE
      mem_rsp_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    lsu_wbu_ready = 1'b0; mem_rsp_valid = 1'b0;
    check({tag, ".after_wbu_valid"}, lsu_wbu_valid, 0);
    check({tag, ".after_exu_ready"}, exu_lsu_ready, 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string       tag;
    logic        ld, st;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr, wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          req_d, wbu_d;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"pass",  0, 0, 2'd0, 0, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 0,
                 64'h1234, 8'h00, 64'h0, 0};
    vecs[1]  = '{"lb",    1, 0, 2'd0, 0, 64'h8000_0003, 64'h0, 5'd7, 64'h0000_0000_80FF_0000, 0, 0,
                 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 0};
    vecs[2]  = '{"lbu",   1, 0, 2'd0, 1, 64'h8000_0003, 64'h0, 5'd8, 64'h0000_0000_80FF_0000, 0, 0,
                 64'h80, 8'h00, 64'h0, 0};
    vecs[3]  = '{"sh",    0, 1, 2'd1, 0, 64'h8000_0006, 64'hABCD, 5'd9, 64'h5555_5555_5555_5555, 0, 0,
                 64'h0, 8'hC0, 64'hABCD_0000_0000_0000, 0};
    vecs[4]  = '{"bp_sw", 0, 1, 2'd2, 0, 64'h1000_0004, 64'h1122_3344_DEAD_BEEF, 5'd10, 64'h0, 4, 3,
                 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0};
    vecs[5]  = '{"bp_ld", 1, 0, 2'd3, 0, 64'h2000_0008, 64'h0, 5'd11, 64'hCAFE_F00D_1234_5678, 4, 3,
                 64'hCAFE_F00D_1234_5678, 8'h00, 64'h0, 0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[6]  = '{"lw_off2", 1, 0, 2'd2, 0, 64'h8000_0002, 64'h0, 5'd12, 64'h1122_3344_5566_7788, 0, 0,
                 64'h0, 8'h00, 64'h0, 1};
    vecs[9]  = '{"ld_off5", 1, 0, 2'd3, 0, 64'h4000_0005, 64'h0, 5'd15, 64'h8070_6050_4030_2010, 0, 0,
                 64'h0, 8'h00, 64'h0, 1};
`else
    vecs[6]  = '{"lw_off2", 1, 0, 2'd2, 0, 64'h8000_0002, 64'h0, 5'd12, 64'h1122_3344_5566_7788, 0, 0,
                 64'h3344_5566, 8'h00, 64'h0, 0};
    vecs[9]  = '{"ld_off5", 1, 0, 2'd3, 0, 64'h4000_0005, 64'h0, 5'd15, 64'h8070_6050_4030_2010, 0, 0,
                 64'h0080_7060, 8'h00, 64'h0, 0};
`endif
    vecs[7]  = '{"ld_st", 1, 1, 2'd3, 0, 64'h3000_0000, 64'hFFFF, 5'd13, 64'h8877_6655_4433_2211, 0, 0,
                 64'h8877_6655_4433_2211, 8'h00, 64'h0, 0};
    vecs[8]  = '{"lh_hi", 1, 0, 2'd1, 0, 64'h5000_0006, 64'h0, 5'd14, 64'h8001_0000_0000_0000, 0, 0,
                 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0, 0};
    vecs[10] = '{"sb_l7", 0, 1, 2'd0, 0, 64'h6000_0007, 64'h12EF, 5'd16, 64'h0, 0, 0,
                 64'h0, 8'h80, 64'hEF00_0000_0000_0000, 0};
    vecs[11] = '{"lwu",   1, 0, 2'd2, 1, 64'h7000_0004, 64'h0, 5'd17, 64'hF000_0001_1234_5678, 0, 0,
                 64'hF000_0001, 8'h00, 64'h0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    #1;
    apply_reset();
    check("reset.dbg_state", lsu_dbg_state, 0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].tag, vecs[i].ld, vecs[i].st, vecs[i].size, vecs[i].uns,
             vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].rdata,
             vecs[i].req_d, 0, vecs[i].wbu_d,
             vecs[i].exp_data, vecs[i].exp_mask, vecs[i].exp_wdata, vecs[i].exp_mis);

    // Reset while waiting for the response, then a stale response.
    exu_lsu_valid = 1'b1; lsu_load = 1'b1; lsu_store = 1'b0; lsu_size = 2'd3;
    lsu_unsigned = 1'b0; lsu_addr = 64'h9000_0000; lsu_rd = 5'd20;
    @(posedge clk); #1;
    exu_lsu_valid = 1'b0; mem_req_ready = 1'b1;
    check("rstw.req_valid", mem_req_valid, 1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("rstw.in_wait", lsu_dbg_state, 2);
    rst = 1'b1;
    #1;
    check("rstw.exu_ready_low", exu_lsu_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("rstw.exu_ready", exu_lsu_ready, 1);
    check("rstw.idle", lsu_dbg_state, 0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("rstw.stale_wbu_valid", lsu_wbu_valid, 0);
    check("rstw.stale_idle", lsu_dbg_state, 0);
    check("rstw.stale_exu_ready", exu_lsu_ready, 1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      int          kind  = $urandom_range(0, 3);
      logic        ld    = (kind == 1) || (kind == 3);
      logic        st    = (kind == 2) || (kind == 3);
      logic [1:0]  size  = 2'($urandom_range(0, 3));
      logic        uns   = 1'($urandom);
      logic [63:0] addr  = {$urandom, $urandom};
      logic [63:0] wdata = {$urandom, $urandom};
      logic [63:0] rdata = {$urandom, $urandom};
      logic [4:0]  rd    = 5'($urandom);
      logic        mis   = model_mis(ld, st, size, addr);
      logic [63:0] exp_d;
      logic [7:0]  exp_m;
      if (mis)     exp_d = '0;
      else if (ld) exp_d = model_load(size, uns, addr, rdata);
      else if (st) exp_d = '0;
      else         exp_d = addr;
      exp_m = (st && !ld) ? model_mask(size, addr) : 8'h00;
      run_op($sformatf("rnd%0d", n), ld, st, size, uns, addr, wdata, rd, rdata,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             exp_d, exp_m, model_wdata(addr, wdata), mis);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
